// File: rtl/store_exec_unit.sv
// store_exec_unit: multi-cycle store sequencer (effective address, byte-lane steering, held write request).
// Optional REQ-phase timeout abort is built when STORE_TIMEOUT_EN is defined.
module store_exec_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [31:0] store_data,
  input  logic [15:0] imm,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be
);

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BEW  = 4;
  localparam int unsigned OPW  = 6;
  localparam int unsigned IMMW = 16;
  localparam int unsigned CNTW = 8;

  localparam logic [OPW-1:0] OP_SW = 6'b101011;
  localparam logic [OPW-1:0] OP_SH = 6'b101001;
  localparam logic [OPW-1:0] OP_SB = 6'b101000;

  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [AW-1:0]   base_q, base_d;
  logic [DW-1:0]   sdata_q, sdata_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BEW-1:0]  be_q, be_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            wr_q, wr_d;

  logic            is_store_c;
  logic [AW-1:0]   ea_c;
  logic [BEW-1:0]  be_c;
  logic [DW-1:0]   wdata_c;
  logic            misaligned_c;

  assign is_store_c = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
  assign ea_c       = base_q + {{(AW-IMMW){imm_q[IMMW-1]}}, imm_q};

`ifdef STORE_TIMEOUT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            timeout_c;

  // Fires on the REQ cycle that would make TIMEOUT_CYCLES unacknowledged write cycles.
  assign timeout_c = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^CNTW'(TIMEOUT_CYCLES);
`endif

  // Byte-lane steering and alignment check from the latched operands.
  always_comb begin : lane_steer
    be_c         = '0;
    wdata_c      = sdata_q;
    misaligned_c = 1'b0;
    case (op_q)
      OP_SW: begin
        be_c         = 4'b1111;
        misaligned_c = (ea_c[1:0] != 2'b00);
      end
      OP_SH: begin
        be_c         = ea_c[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{sdata_q[15:0]}};
        misaligned_c = ea_c[0];
      end
      OP_SB: begin
        be_c    = 4'b0001 << ea_c[1:0];
        wdata_c = {4{sdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin : fsm_next
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    sdata_d = sdata_q;
    imm_d   = imm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wr_d    = wr_q;
`ifdef STORE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && is_store_c) begin
          op_d    = opcode;
          base_d  = base;
          sdata_d = store_data;
          imm_d   = imm;
          state_d = CALC;
        end
      end
      CALC: begin
        addr_d  = ea_c;
        wdata_d = wdata_c;
        be_d    = be_c;
        if (misaligned_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = REQ;
          wr_d    = 1'b1;
`ifdef STORE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          wr_d    = 1'b0;
        end
`ifdef STORE_TIMEOUT_EN
        else if (timeout_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          wr_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      base_q  <= '0;
      sdata_q <= '0;
      imm_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      sdata_q <= sdata_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

`ifdef STORE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin : timeout_cnt
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_store_exec_unit.sv
// Scoreboard bench for store_exec_unit: stimulus pushes model predictions, a monitor checks DUT responses.
module tb_store_exec_unit;

  localparam int unsigned T_CYC = 4;
`ifdef STORE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] base = '0;
  logic [31:0] store_data = '0;
  logic [15:0] imm = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  store_exec_unit #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base(base),
    .store_data(store_data), .imm(imm), .mem_ack(mem_ack), .busy(busy),
    .done(done), .err(err), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    int          wr_cycles;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_delay = 1;
  int   req_cnt = 0;
  bit   in_rst_test = 1'b0;
  logic held_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain arithmetic over the store rules.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] b, input logic [31:0] d,
                                 input logic [15:0] im, input int k, input int c);
    exp_t   e;
    longint ea;
    int     off;
    bit     mis;
    ea     = longint'(b) + ((im >= 16'h8000) ? longint'(im) - 65536 : longint'(im));
    e.addr = ea[31:0];
    off    = int'(e.addr % 4);
    mis    = 1'b0;
    e.be   = 4'h0;
    e.wdata = d;
    if (op == OP_SW) begin
      e.be = 4'hF;
      mis  = (off != 0);
    end else if (op == OP_SH) begin
      e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
      e.wdata = 32'(d[15:0]) * 32'h00010001;
      mis     = (off % 2 != 0);
    end else begin
      e.be    = 4'(1 << off);
      e.wdata = 32'(d[7:0]) * 32'h01010101;
    end
    if (mis) begin
      e.err = 1'b1; e.wr_cycles = 0;
    end else if (TO_EN && k > int'(T_CYC)) begin
      e.err = 1'b1; e.wr_cycles = int'(T_CYC);
    end else begin
      e.err = 1'b0; e.wr_cycles = k;
    end
    e.done_cyc = c + 2 + e.wr_cycles;
    return e;
  endfunction

  // Memory responder: acks after ack_delay write cycles; random noise on ack when no write is pending.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      req_cnt++;
      mem_ack = (req_cnt == ack_delay);
    end else begin
      req_cnt = 0;
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares write requests and completions against the scoreboard.
  int          wr_cycles = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  exp_t        cur;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      wr_cycles = 0;
    end else if (!in_rst_test) begin
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_write), 32'd0);
        end else if (wr_cycles == 0) begin
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          chk("mem_be", 32'(mem_be), 32'(exp_q[0].be));
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be;
        end else begin
          chk("addr_stable", mem_addr, cap_addr);
          chk("wdata_stable", mem_wdata, cap_wdata);
          chk("be_stable", 32'(mem_be), 32'(cap_be));
        end
        wr_cycles++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("err", 32'(err), 32'(cur.err));
          chk("write_cycles", 32'(wr_cycles), 32'(cur.wr_cycles));
          chk("done_cycle", 32'(cyc), 32'(cur.done_cyc));
          held_err = cur.err;
        end
        wr_cycles = 0;
      end else begin
        chk("err_hold", 32'(err), 32'(held_err));
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [31:0] d,
                       input logic [15:0] im, input int k, input bit spurious);
    @(negedge clk);
    opcode = op; base = b; store_data = d; imm = im; start = 1'b1; ack_delay = k;
    exp_q.push_back(model(op, b, d, im, k, cyc));
    @(negedge clk);
    start = 1'b0; opcode = 6'($urandom); base = $urandom; store_data = $urandom; imm = 16'($urandom);
    if (spurious) begin
      @(negedge clk);
      start = 1'b1; opcode = OP_SW;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic idle_junk();
    logic [5:0] op;
    op = 6'($urandom);
    if (op == OP_SW || op == OP_SH || op == OP_SB) op = 6'b000000;
    @(negedge clk);
    start = 1'b1; opcode = op;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_req();
    @(negedge clk);
    in_rst_test = 1'b1;
    opcode = OP_SW; base = 32'h0000_3000; imm = 16'h0000; store_data = $urandom;
    ack_delay = 100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("req_write_before_rst", 32'(mem_write), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    held_err = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    in_rst_test = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    repeat (2) @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_mem_write", 32'(mem_write), 32'd0);
    chk("init_done_err", 32'({done, err}), 32'd0);
    chk("init_addr", mem_addr, 32'd0);
    chk("init_wdata", mem_wdata, 32'd0);
    chk("init_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    issue(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF, 16'h0004, 1, 1'b0);
    issue(OP_SB, 32'h0000_2000, 32'h0000_00EF, 16'hFFFF, 2, 1'b0);
    issue(OP_SH, 32'h0000_1001, 32'h1234_5678, 16'h0000, 1, 1'b0);
    issue(OP_SH, 32'h0000_1002, 32'h1234_ABCD, 16'h0000, 1, 1'b0);
    issue(OP_SW, 32'h0000_4000, 32'hCAFE_F00D, 16'h0010, 3, 1'b1);
    issue(OP_SW, 32'h0000_1002, 32'h0BAD_0BAD, 16'h0000, 1, 1'b1);
    issue(OP_SW, 32'h0000_0000, 32'h5555_AAAA, 16'h8000, 2, 1'b0);
    issue(OP_SW, 32'hFFFF_FFFC, 32'h0102_0304, 16'h0008, 1, 1'b0);
    idle_junk();
    reset_mid_req();
    issue(OP_SW, 32'h0000_5000, 32'h89AB_CDEF, 16'h0000, 1, 1'b0);
    issue(OP_SW, 32'h0000_6000, 32'h7777_1111, 16'h0000, 55, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_SW;
        1:       op = OP_SH;
        default: op = OP_SB;
      endcase
      if ($urandom_range(0, 9) == 0) idle_junk();
      issue(op, $urandom, $urandom, 16'($urandom), int'($urandom_range(1, 6)),
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
